bkm_iter_ctrl: RTL
==================

# bkm_iter_ctrl

Iteration sequencer for the BKM datapath. It owns the x/y iteration registers and steps a `multiply_by_d` instance through N iterations, one per accepted digit pair. It consumes a digit stream over a valid/ready handshake and returns the final x/y through an output handshake. It sits between the BKM digit-selection logic and the `multiply_by_d` datapath inside `xfire_fpu_bkm`.

## Interface
- `W`, 4: datapath word width, signed two's complement.
- `N`, 4: iterations per operation, 1 ≤ N ≤ 2^W−1.
- `CW`, $clog2(N+1): iteration counter width, derived.

Ports:
- `clk` in 1: clock; single clock domain, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ena` in 1: global enable; when low, all state and outputs hold.
- `start` in 1: begin an operation; sampled only in IDLE.
- `x0`, `y0` in W: initial operands, captured on the accepted `start`.
- `dig_valid` in 1: digit pair present.
- `dig_ready` out 1: controller accepts a digit this cycle.
- `d_x`, `d_y` in 2: digits; 2'b00 = 0, 2'b01 = +1, 2'b11 = −1, 2'b10 = illegal.
- `md_d_x`, `md_d_y` out 2: digits driven to `multiply_by_d`.
- `md_x_in`, `md_y_in` out W: current x/y registers driven to `multiply_by_d`.
- `md_x_out`, `md_y_out` in W: datapath result; `multiply_by_d` is combinational with `md_x_out = d_x·x_in` and `md_y_out = d_y·y_in`.
- `busy` out 1: high in RUN and DONE.
- `iter` out CW: current iteration index n.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `x_res`, `y_res` out W: final x/y.
- `err` out 1: sticky illegal-digit flag (see Configuration).

## Operation
- States: IDLE, RUN, DONE. `rst` forces IDLE.
- Reset values: x, y, `iter`, `x_res`, `y_res` = 0; `busy`, `out_valid`, `dig_ready`, `err` = 0; `md_d_*` = 2'b00.
- IDLE:
  - `start` with `ena` → load x←x0, y←y0, n←0, clear `err`, go to RUN.
- RUN:
  - `dig_ready` = 1.
  - `md_d_*` = `d_*`, `md_*_in` = x, y (combinational passthrough).
  - On `dig_valid` with `ena`:
    - x ← x + (md_x_out >>> n); y ← y + (md_y_out >>> n).
    - Shift is arithmetic. Sums truncate to W bits (wrap, no saturation).
    - n ← n+1.
  - Accepting the digit with n = N−1 → go to DONE, latching the updated x/y into `x_res`/`y_res`.
  - `dig_valid` low: stall, all state holds.
- DONE:
  - `out_valid` = 1; `x_res`/`y_res` stay stable.
  - `out_ready` with `ena` → go to IDLE; `out_valid` drops the next cycle.
- Boundary rules:
  - `start` in RUN or DONE is ignored.
  - `start` together with `rst` → reset wins.
  - `rst` mid-RUN aborts; no result is produced.
  - `dig_ready` is low outside RUN; digits presented there are not consumed.
  - `out_ready` outside DONE is ignored.
- Shift amount n ranges over 0..N−1. Shifts ≥ W give 0 or −1 per the sign.

## Timing
- `start` accepted at edge t → RUN from t+1. The first digit is accepted at the earliest at edge t+1.
- With `dig_valid` held high, `out_valid` rises at t+N+1. Start-to-result latency is N+1 cycles minimum.
- One digit is accepted per cycle; each digit stall adds 1 cycle.
- Back-to-back operations: `out_ready` at edge u → IDLE at u+1; a new `start` is accepted at u+1.
- `ena` low freezes the FSM, counters, registers and handshake outputs. `dig_ready` and `out_valid` keep their state values.

## Configuration
- Macro: `BKM_ITER_CTRL_DIGIT_CHK_EN`.
- Defined:
  - In RUN, an accepted digit with `d_x` or `d_y` = 2'b10 sets `err`.
  - That digit is not applied: x/y/n unchanged.
  - The FSM goes to DONE with `x_res`/`y_res` = current x/y.
  - `err` stays set until the next accepted `start` or `rst`.
- Undefined:
  - 2'b10 passes through to the datapath unchanged.
  - `err` is tied to 0.

## Test plan
- Reset: assert `rst` for 2 cycles mid-RUN → next cycle IDLE, all outputs 0, `busy` = 0; a later digit is not consumed.
- Nominal (W=4, N=4): x0=2, y0=−4, digits (+1,−1) ×4, `dig_valid` steady → x sequence 4, 6, 7, 7; y sequence 0, 0, 0, 0; `out_valid` at start+5 with `x_res`=7, `y_res`=0.
- Stall: same vectors with `dig_valid` low for 3 cycles after the second digit → same result, `out_valid` at start+8; `iter` holds 2 during the stall.
- Output backpressure and back-to-back: hold `out_ready` low 4 cycles → `x_res`/`y_res` stable, `start` ignored. Then raise `out_ready` → IDLE next cycle; an immediate second `start` with x0=1, digits (0,0) → `x_res`=1.
- Wrap: x0=7, digit (+1,0) at n=0 → x = 7+7 = 14, truncated to −2.
- Illegal digit (macro defined): second digit `d_x`=2'b10 → `err`=1, DONE with `x_res` equal to x after the first digit. With the macro undefined, `err` stays 0 and all 4 iterations run.

Source files
------------

// File: rtl/bkm_iter_ctrl_if.sv
// Digit-stream and result handshakes of the BKM iteration sequencer.
// The slave modport is the controller side; master is the digit source / result consumer.
interface bkm_iter_ctrl_if #(
   parameter int W = 4
);
   logic         dig_valid;
   logic         dig_ready;
   logic [1:0]   d_x;
   logic [1:0]   d_y;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] x_res;
   logic [W-1:0] y_res;

   modport slave (
      input  dig_valid, d_x, d_y, out_ready,
      output dig_ready, out_valid, x_res, y_res
   );

   modport master (
      output dig_valid, d_x, d_y, out_ready,
      input  dig_ready, out_valid, x_res, y_res
   );
endinterface

// File: rtl/bkm_iter_ctrl.sv
// BKM iteration sequencer: steps x/y through N shift-and-add iterations via multiply_by_d.
// Optional illegal-digit check enabled by defining BKM_ITER_CTRL_DIGIT_CHK_EN.
module bkm_iter_ctrl #(
   parameter  int W  = 4,
   parameter  int N  = 4,
   localparam int CW = $clog2(N + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic                start,
   input  logic [W-1:0]        x0,
   input  logic [W-1:0]        y0,
   bkm_iter_ctrl_if.slave      io,
   output logic [1:0]          md_d_x,
   output logic [1:0]          md_d_y,
   output logic [W-1:0]        md_x_in,
   output logic [W-1:0]        md_y_in,
   input  logic [W-1:0]        md_x_out,
   input  logic [W-1:0]        md_y_out,
   output logic                busy,
   output logic [CW-1:0]       iter,
   output logic                err
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_reg, state_next;
   logic [CW-1:0]        n_reg, n_next;
   logic [1:0][W-1:0]    xy_reg, xy_next;
   logic [1:0][W-1:0]    res_reg, res_next;
   logic                 err_reg, err_next;
   logic [1:0][W-1:0]    md_out;
   logic [1:0][W-1:0]    step_val;
   logic                 bad_digit;

   assign md_out[0] = md_x_out;
   assign md_out[1] = md_y_out;

   // Lane 0 is x, lane 1 is y; both take the same shifted accumulate step.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         logic signed [W-1:0] shifted;
         assign shifted      = $signed(md_out[gi]) >>> n_reg;
         assign step_val[gi] = xy_reg[gi] + shifted;
      end
   endgenerate

`ifdef BKM_ITER_CTRL_DIGIT_CHK_EN
   assign bad_digit = (io.d_x == 2'b10) || (io.d_y == 2'b10);
`else
   assign bad_digit = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      n_next     = n_reg;
      xy_next    = xy_reg;
      res_next   = res_reg;
      err_next   = err_reg;
      if (ena) begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  xy_next[0] = x0;
                  xy_next[1] = y0;
                  n_next     = '0;
                  err_next   = 1'b0;
                  state_next = RUN;
               end
            end
            RUN: begin
               if (io.dig_valid) begin
                  if (bad_digit) begin
                     // Illegal digit is dropped; result is the state before it.
                     err_next   = 1'b1;
                     res_next   = xy_reg;
                     state_next = DONE;
                  end else begin
                     xy_next = step_val;
                     n_next  = n_reg + 1'b1;
                     if (n_reg == CW'(N - 1)) begin
                        res_next   = step_val;
                        state_next = DONE;
                     end
                  end
               end
            end
            DONE: begin
               if (io.out_ready) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         n_reg     <= '0;
         xy_reg    <= '0;
         res_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         n_reg     <= n_next;
         xy_reg    <= xy_next;
         res_reg   <= res_next;
         err_reg   <= err_next;
      end
   end

   assign io.dig_ready = (state_reg == RUN);
   assign io.out_valid = (state_reg == DONE);
   assign io.x_res     = res_reg[0];
   assign io.y_res     = res_reg[1];
   assign md_d_x       = (state_reg == RUN) ? io.d_x : 2'b00;
   assign md_d_y       = (state_reg == RUN) ? io.d_y : 2'b00;
   assign md_x_in      = xy_reg[0];
   assign md_y_in      = xy_reg[1];
   assign busy         = (state_reg != IDLE);
   assign iter         = n_reg;
   assign err          = err_reg;
endmodule
